pipe_elastic_reg: RTL
=====================

Name: pipe_elastic_reg

Overview:
- Parametrised successor to the plain stall/flush pipeline register.
- Chain of NSTAGE elastic stages, each with a valid/ready handshake and a 2-entry skid buffer.
- Sustains full throughput with a registered (non-combinational) in_ready, so stall does not propagate combinationally across pipeline boundaries.
- Sits between core pipeline stages (IF/ID/EX/MEM/WB) and replaces the global stall wire with per-boundary back-pressure; a global flush kills all in-flight entries.

Parameters:
- BW, 512, payload width in bits
- NSTAGE, 1, number of chained skid stages; legal range 1..8
- CW, 16, width of the performance counters (used only with the optional feature)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all entries in all stages
- in_valid  in  1  upstream has data
- in_ready  out  1  block accepts data; depends on state registers only
- in_data  in  BW  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts
- out_data  out  BW  head payload; '0 when out_valid=0
- stall_cnt  out  CW  cycles with out_valid & !out_ready (optional feature)
- bubble_cnt  out  CW  cycles with !out_valid & out_ready (optional feature)

Behaviour:
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Stage k's output handshake is stage k+1's input handshake.
- Per-stage state (2 bits): EMPTY, BUSY (main valid), FULL (main+skid valid).
- Per-stage outputs: in_ready = (state != FULL); out_valid = (state != EMPTY); out_data = main.
- EMPTY:
  - in_fire -> BUSY, main <= in_data.
- BUSY:
  - in_fire & out_fire -> BUSY, main <= in_data.
  - in_fire & !out_fire -> FULL, skid <= in_data.
  - !in_fire & out_fire -> EMPTY, main <= '0.
  - neither -> hold.
- FULL (in_ready=0):
  - out_fire -> BUSY, main <= skid, skid <= '0.
  - else hold.
- Order is strictly FIFO; no reordering and no drops, except on flush.
- Flush has priority over all transitions. Every stage goes to EMPTY next cycle and main/skid <= '0.
  - in_fire in the flush cycle: data is discarded.
  - out_fire in the flush cycle: counts as delivered; downstream owns it.
- Reset (async, any time, including mid-transfer): all stages EMPTY, data '0, in_ready=1 after reset, out_valid=0, counters 0.
- Latency: with out_ready held 1, in_fire at cycle t gives out_valid with that data at t+NSTAGE. Throughput is 1 per cycle.
- Capacity is 2*NSTAGE entries. With out_ready=0, in_ready drops after 2*NSTAGE accepted beats, one cycle after the last accept.
- out_ready may toggle every cycle. out_data is stable while out_valid & !out_ready.
- in_valid may drop without a transfer; no upstream stability is required.

Optional Feature:
- Macro: PIPE_ELASTIC_PERF_EN.
- With the macro: stall_cnt and bubble_cnt each increment by 1 on their condition.
  - Saturate at 2^CW-1; no wrap.
  - Cleared by reset only; flush does not clear them.
- Without the macro: both ports remain and are tied to '0. No counter flops are synthesised.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] {ST_EMPTY, ST_BUSY, ST_FULL} skid_state_t
  - localparam NSTAGE_MAX = 8
- Sub-module skid_stage (BW parameter): one EMPTY/BUSY/FULL slot.
- Top pipe_elastic_reg: generate-chains NSTAGE instances, fans out flush to every stage, and holds the counters.

Test Plan:
- Reset mid-stream: assert rst low while FULL -> out_valid=0, in_ready=1, out_data=0 immediately (async); counters 0.
- Streaming: NSTAGE=2, out_ready=1, send 0x1..0x10 back-to-back -> first beat out at t+2, then one beat per cycle, order preserved, in_ready never drops.
- Back-pressure: NSTAGE=1, out_ready=0, in_valid=1 with 0xA,0xB,0xC -> 0xA and 0xB accepted, in_ready=0, 0xC held. Then out_ready=1 -> 0xA,0xB,0xC in order with no loss.
- Flush: NSTAGE=3, 5 entries in flight, flush=1 with in_valid=1 (0xDEAD) -> next cycle out_valid=0 everywhere, 0xDEAD never appears, in_ready=1.
- Random toggle: random in_valid/out_ready for 10k cycles -> scoreboard sees exact FIFO order and no duplicates.
- PERF: with PIPE_ELASTIC_PERF_EN and CW=4, hold out_valid & !out_ready for 20 cycles -> stall_cnt=15 (saturated). Without the macro -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and limits for the elastic pipeline register
//
// skid_state_t : occupancy of one skid stage (EMPTY / BUSY / FULL)
// NSTAGE_MAX   : deepest supported chain of skid stages

package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    localparam int NSTAGE_MAX = 8;

endpackage

// File: rtl/skid_stage.sv
// rtl/skid_stage.sv - one elastic slot with a main register and a skid register
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   flush             synchronous kill of both entries
//   in_valid/in_ready/in_data     upstream handshake (in_ready is registered state)
//   out_valid/out_ready/out_data  downstream handshake (out_data is the main entry)

module skid_stage
    import pipe_pkg::*;
#(
    parameter int BW = 512
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data
);

    skid_state_t   state;
    logic [BW-1:0] main_q;
    logic [BW-1:0] skid_q;
    logic          in_fire;
    logic          out_fire;

    // Both handshake outputs come straight from the state register, so a
    // downstream stall never reaches upstream in the same cycle.
    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign out_data  = main_q;

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // main_q/skid_q are cleared whenever they stop holding a live entry, which
    // keeps out_data at zero whenever out_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else if (flush) begin
            state  <= ST_EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state  <= ST_BUSY;
                        main_q <= in_data;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_q <= in_data;
                    end else if (in_fire) begin
                        // Downstream is stalled: park the new beat behind main.
                        state  <= ST_FULL;
                        skid_q <= in_data;
                    end else if (out_fire) begin
                        state  <= ST_EMPTY;
                        main_q <= '0;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state  <= ST_BUSY;
                        main_q <= skid_q;
                        skid_q <= '0;
                    end
                end
                default: begin
                    state  <= ST_EMPTY;
                    main_q <= '0;
                    skid_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_elastic_reg.sv
// rtl/pipe_elastic_reg.sv - chain of NSTAGE elastic skid stages with global flush
//
// Optional feature macro: PIPE_ELASTIC_PERF_EN (saturating stall/bubble counters).
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   flush               synchronous kill of every in-flight entry
//   in_valid/in_ready/in_data     upstream handshake (in_ready is registered)
//   out_valid/out_ready/out_data  downstream handshake (out_data is 0 when idle)
//   stall_cnt           cycles with out_valid & !out_ready (0 without the macro)
//   bubble_cnt          cycles with !out_valid & out_ready (0 without the macro)

module pipe_elastic_reg
    import pipe_pkg::*;
#(
    parameter int BW     = 512,
    parameter int NSTAGE = 1,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_data,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] bubble_cnt
);

    // Boundary k sits in front of stage k; boundary NSTAGE is the block output.
    logic [NSTAGE:0] vld;
    logic [NSTAGE:0] rdy;
    logic [BW-1:0]   dat [NSTAGE+1];

    assign vld[0]      = in_valid;
    assign dat[0]      = in_data;
    assign in_ready    = rdy[0];

    assign out_valid   = vld[NSTAGE];
    assign out_data    = dat[NSTAGE];
    assign rdy[NSTAGE] = out_ready;

    for (genvar g = 0; g < NSTAGE; g++) begin : g_stage
        skid_stage #(
            .BW(BW)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (vld[g]),
            .in_ready (rdy[g]),
            .in_data  (dat[g]),
            .out_valid(vld[g+1]),
            .out_ready(rdy[g+1]),
            .out_data (dat[g+1])
        );
    end

`ifdef PIPE_ELASTIC_PERF_EN
    logic [CW-1:0] stall_q;
    logic [CW-1:0] bubble_q;

    // Counters saturate and survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_q != {CW{1'b1}})) begin
                stall_q <= stall_q + CW'(1);
            end
            if (!out_valid && out_ready && (bubble_q != {CW{1'b1}})) begin
                bubble_q <= bubble_q + CW'(1);
            end
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule
